// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller: digit count,
// blank pattern, segment bit order and the hex glyph table.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);
  localparam logic [7:0]  SEG_BLANK  = 8'hFF;
  localparam logic [6:0]  GLYPH_OFF  = 7'h7F;

  // seg bus order is {dp,g,f,e,d,c,b,a}, all active-low
  localparam int SEG_A  = 0;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] HEX_SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // Bit k set when digit k sits above the most significant nonzero nibble.
  // Digit 0 is never blanked so a zero value still shows one "0".
  function automatic logic [NUM_DIGITS-1:0] lz_blank_mask(input logic [31:0] v);
    logic seen;
    lz_blank_mask = '0;
    seen = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      seen = seen | (v[4*k +: 4] != 4'h0);
      lz_blank_mask[k] = ~seen;
    end
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// CPU-side load/enable signals and display-side outputs of seg7_scan_ctrl.
interface seg7_scan_ctrl_if;
  // load is a one-cycle strobe with no backpressure; busy is status only and
  // never blocks a load (a later load simply overwrites the pending value).
  logic        en;
  logic [31:0] data_in;
  logic        load;
  logic [7:0]  dp_mask;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        frame_done;
  logic        busy;

  modport master (
    output en, data_in, load, dp_mask,
    input  an, seg, frame_done, busy
  );

  modport slave (
    input  en, data_in, load, dp_mask,
    output an, seg, frame_done, busy
  );
endinterface

// File: rtl/seg7_scan_ctrl_decoder.sv
// 3-to-8 decoder with active-low outputs, used as the digit select.
module Decoder3_8 (
  input  logic [2:0] a_i,
  output logic [7:0] y_n_o
);
  assign y_n_o = ~(8'b0000_0001 << a_i);
endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 8-digit seven-segment scanner with frame-boundary shadowing.
// Optional leading-zero blanking is built when SEG7_LZ_BLANK_EN is defined.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic           clk,
  input  logic           rst_n,
  seg7_scan_ctrl_if.slave bus
);

  localparam int unsigned PRE_W = 20;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      pend_q, pend_d;
  logic [31:0]      shadow_q, shadow_d;
  logic             busy_q, busy_d;
  logic             fd_q, fd_d;
  logic [7:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;
  logic             tick, boundary;
  logic [3:0]       nib;
  logic [6:0]       glyph;
  logic [7:0]       dec_an;
`ifdef SEG7_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
`endif

  Decoder3_8 u_dec (
    .a_i   (idx_q),
    .y_n_o (dec_an)
  );

  always_comb begin
    tick     = (pre_q == PRE_W'(SCAN_DIV - 1));
    boundary = tick && (idx_q == LAST_IDX);
    pre_d    = tick ? '0 : pre_q + 1'b1;
    idx_d    = tick ? idx_q + 1'b1 : idx_q;
    pend_d   = bus.load ? bus.data_in : pend_q;
    // A load coinciding with the boundary keeps busy: the new value still waits.
    busy_d   = bus.load | (busy_q & ~boundary);
    shadow_d = (boundary && busy_q) ? pend_q : shadow_q;
    fd_d     = boundary;

    nib   = shadow_q[{idx_q, 2'b00} +: 4];
    glyph = HEX_SEG[nib][SEG_G:SEG_A];
`ifdef SEG7_LZ_BLANK_EN
    blank_d = (boundary && busy_q) ? lz_blank_mask(pend_q) : blank_q;
    if (blank_q[idx_q]) glyph = GLYPH_OFF;
`endif

    an_d  = SEG_BLANK;
    seg_d = SEG_BLANK;
    if (bus.en) begin
      an_d                = dec_an;
      seg_d[SEG_DP]       = ~bus.dp_mask[idx_q];
      seg_d[SEG_G:SEG_A]  = glyph;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q    <= '0;
      idx_q    <= '0;
      pend_q   <= '0;
      shadow_q <= '0;
      busy_q   <= 1'b0;
      fd_q     <= 1'b0;
      an_q     <= SEG_BLANK;
      seg_q    <= SEG_BLANK;
`ifdef SEG7_LZ_BLANK_EN
      blank_q  <= lz_blank_mask(32'h0);
`endif
    end else begin
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      shadow_q <= shadow_d;
      busy_q   <= busy_d;
      fd_q     <= fd_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
`ifdef SEG7_LZ_BLANK_EN
      blank_q  <= blank_d;
`endif
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.frame_done = fd_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with SCAN_DIV=4 (32-cycle frames).
module tb_seg7_scan_ctrl;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;
  logic [7:0] exp_q[$];

  seg7_scan_ctrl_if bus ();

  seg7_scan_ctrl #(.SCAN_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Expected frames, digit d in bits [8d+7:8d]
  localparam logic [63:0] F_1234  = 64'hF9A4B0998883C6A1;
  localparam logic [63:0] F_FFFF  = 64'h8E8E8E8E8E8E8E8E;
`ifdef SEG7_LZ_BLANK_EN
  localparam logic [63:0] F_7     = 64'hFFFFFFFFFFFFFFF8;
  localparam logic [63:0] F_5     = 64'hFFFFFFFFFFFFFF92;
  localparam logic [63:0] F_5DP   = 64'hFFFFFFFFFFFFFF12;
  localparam logic [63:0] F_A05   = 64'hFFFFFFFFFF88C092;
`else
  localparam logic [63:0] F_7     = 64'hC0C0C0C0C0C0C0F8;
  localparam logic [63:0] F_5     = 64'hC0C0C0C0C0C0C092;
  localparam logic [63:0] F_5DP   = 64'hC0C0C0C0C0C0C012;
  localparam logic [63:0] F_A05   = 64'hC0C0C0C0C088C092;
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_load(input logic [31:0] v);
    bus.load    = 1'b1;
    bus.data_in = v;
    @(negedge clk);
    bus.load    = 1'b0;
  endtask

  task automatic wait_fd();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.frame_done) seen = 1'b1;
    end
    chk("frame_done_wait", {31'b0, seen}, 32'd1);
  endtask

  // Called at the negedge where frame_done is high (or 4*first_d cycles later).
  task automatic check_frame(input logic [63:0] exp, input int first_d);
    for (int d = first_d; d < 8; d++) exp_q.push_back(exp[8*d +: 8]);
    for (int d = first_d; d < 8; d++) begin
      @(negedge clk);
      chk($sformatf("an_d%0d", d), {24'b0, bus.an}, {24'b0, ~(8'h01 << d)});
      chk($sformatf("seg_d%0d", d), {24'b0, bus.seg}, {24'b0, exp_q.pop_front()});
      repeat (3) @(negedge clk);
    end
    chk("frame_done_end", {31'b0, bus.frame_done}, 32'd1);
  endtask

  initial begin
    n_total     = 0;
    n_bad       = 0;
    rst_n       = 1'b0;
    bus.en      = 1'b1;
    bus.load    = 1'b0;
    bus.data_in = '0;
    bus.dp_mask = '0;

    // reset state and the default scan of value 0
    repeat (3) @(negedge clk);
    chk("rst_an", {24'b0, bus.an}, 32'hFF);
    chk("rst_seg", {24'b0, bus.seg}, 32'hFF);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_fd", {31'b0, bus.frame_done}, 32'd0);
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      chk($sformatf("scan_an_%0d", k), {24'b0, bus.an}, {24'b0, ~(8'h01 << ((k - 1) / 4))});
      if (k <= 4) chk("scan_seg0", {24'b0, bus.seg}, 32'hC0);
      if (k == 31) chk("scan_fd_low", {31'b0, bus.frame_done}, 32'd0);
    end
    chk("scan_fd_high", {31'b0, bus.frame_done}, 32'd1);

    // load mid-frame, shown after the next boundary
    do_load(32'h1234ABCD);
    chk("busy_after_load", {31'b0, bus.busy}, 32'd1);
    wait_fd();
    chk("busy_after_bound", {31'b0, bus.busy}, 32'd0);
    check_frame(F_1234, 0);

    // tear-free: two loads mid-frame, old value holds until the boundary
    bus.load    = 1'b1;
    bus.data_in = 32'h0;
    @(negedge clk);
    chk("tear_seg0", {24'b0, bus.seg}, 32'hA1);
    bus.data_in = 32'hFFFFFFFF;
    @(negedge clk);
    bus.load = 1'b0;
    chk("tear_busy", {31'b0, bus.busy}, 32'd1);
    repeat (2) @(negedge clk);
    check_frame(F_1234, 1);
    chk("tear_busy_clr", {31'b0, bus.busy}, 32'd0);
    check_frame(F_FFFF, 0);

    // load coinciding with the boundary cycle
    do_load(32'h7);
    repeat (30) @(negedge clk);
    do_load(32'h5);
    chk("sim_fd", {31'b0, bus.frame_done}, 32'd1);
    chk("sim_busy", {31'b0, bus.busy}, 32'd1);
    check_frame(F_7, 0);
    chk("sim_busy_clr", {31'b0, bus.busy}, 32'd0);
    check_frame(F_5, 0);

    // enable off blanks outputs but frames keep running
    bus.en = 1'b0;
    @(negedge clk);
    chk("en0_an", {24'b0, bus.an}, 32'hFF);
    chk("en0_seg", {24'b0, bus.seg}, 32'hFF);
    wait_fd();
    bus.en      = 1'b1;
    bus.dp_mask = 8'h01;
    check_frame(F_5DP, 0);
    bus.dp_mask = 8'h00;

    do_load(32'h00000A05);
    wait_fd();
    check_frame(F_A05, 0);

    // asynchronous reset mid-slot
    do_load(32'h1234);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_an", {24'b0, bus.an}, 32'hFF);
    chk("arst_seg", {24'b0, bus.seg}, 32'hFF);
    chk("arst_busy", {31'b0, bus.busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("rescan_an_%0d", k), {24'b0, bus.an}, (k <= 4) ? 32'hFE : 32'hFD);
      if (k == 1) chk("rescan_seg0", {24'b0, bus.seg}, 32'hC0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
